iir_input_scheduler: RTL
========================

Name: iir_input_scheduler

Overview:
Upstream feeder for iir_orde1_core. Accepts Q1.15 samples over a valid/ready handshake and buffers them in a small FIFO. Releases exactly one sample per sample-rate tick (48 kHz from the system clock via a programmable divider) as a one-cycle en strobe. Double-buffers the a0/a1/b1 coefficients and commits them only on a sample boundary, with an optional state clear.

Parameters:
DATA_W, 16, sample and coefficient width (Q1.15, signed)
FIFO_DEPTH, 4, input FIFO entries (power of two, >=2)
DIV_W, 16, width of the tick divider

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
s_valid  in  1  upstream sample valid
s_ready  out  1  FIFO can accept; high iff fifo_level < FIFO_DEPTH
s_data  in  DATA_W  signed input sample
div_ratio  in  DIV_W  tick period minus 1, in clk cycles
coef_wr  in  1  one-cycle strobe: load shadow coefficients
coef_a0_in / coef_a1_in / coef_b1_in  in  DATA_W each  new coefficients
coef_clr_req  in  1  sampled with coef_wr: clear core state at commit
coef_busy  out  1  shadow write pending commit
core_en  out  1  one-cycle sample strobe to core en
core_x  out  DATA_W  sample to core x_in; valid while core_en high
core_clear  out  1  one-cycle pulse to core clear_state
core_a0 / core_a1 / core_b1  out  DATA_W each  active coefficients
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
underrun_cnt  out  16  ticks that found the FIFO empty, saturating

Behaviour:
- Reset (async assert, sync deassert by the clk domain owner):
  - FIFO flushed; tick counter = 0; pending and clr flags = 0.
  - core_en = core_clear = 0; core_x = 0; underrun_cnt = 0.
  - core_a0 = 16'sh7FFF, core_a1 = 0, core_b1 = 0 (passthrough).
  - A reset mid-operation discards buffered samples and any pending coefficients.
- Tick counter:
  - Increments every cycle.
  - When cnt >= div_ratio: tick = 1 and cnt <= 0.
  - div_ratio = 0 gives a tick every cycle.
  - A change to div_ratio takes effect on the next compare; the >= compare guarantees no stall when the value shrinks.
- Handshake and push:
  - Push when s_valid && s_ready.
  - s_ready is combinational from the registered level.
  - At full, s_ready = 0 even if a pop occurs in the same cycle (no bypass).
- Tick handling: all outputs are registered, so the response appears one cycle after the tick.
  - Case A, pending commit with clr flag set:
    - core_a*/b1 <= shadow; core_clear = 1; core_en = 0.
    - FIFO is not popped; pending and clr flags cleared.
  - Case B, pending commit without clr flag:
    - core_a*/b1 <= shadow, in the same cycle as that tick's core_en.
    - Pop/underrun rules below apply.
  - Pop or underrun:
    - level > 0: pop; core_en = 1; core_x = head.
    - level = 0: core_en = 1; core_x = 0 (zero-stuff keeps the time base regular); underrun_cnt += 1, saturating at 16'hFFFF.
- Non-tick cycles: core_en = core_clear = 0; core_x holds its last value.
- Latency: a sample pushed into an empty FIFO at cycle N is popped at the first tick at cycle >= N+1 and appears on core_x one cycle later.
- Push and pop in the same cycle (not full): level unchanged; data order preserved (FIFO).
- Coefficient write:
  - coef_wr copies the inputs and coef_clr_req into the shadow and sets pending.
  - A write while pending overwrites the shadow (last write wins); the clr flag is ORed.
  - coef_wr in the same cycle as a tick:
    - The tick commits only the previously pending shadow, if any.
    - The new write lands in the shadow and stays pending for the next tick.
  - coef_busy = pending.

Test Plan:
- Reset values: assert rst for 3 cycles -> core_a0 = 32767, core_a1 = core_b1 = 0, s_ready = 1, fifo_level = 0, core_en = 0, underrun_cnt = 0.
- Pacing and FIFO order: div_ratio = 9, push 16000, -16000, 5, 7 back-to-back -> s_ready drops after the 4th push; core_en pulses exactly every 10 cycles with core_x = 16000, -16000, 5, 7 in order; 5th tick gives core_x = 0 and underrun_cnt = 1.
- Commit without clear: div_ratio = 4, write a0 = 426, a1 = 0, b1 = 32342 mid-period -> coef_busy = 1 until the next tick; the new values appear in the same cycle as that tick's core_en and not earlier.
- Commit with clear: same write with coef_clr_req = 1 and FIFO holding 100 -> the next tick gives core_clear = 1 and core_en = 0 with level unchanged; the following tick gives core_en = 1, core_x = 100.
- Simultaneous events:
  - div_ratio = 0 with one pending write; second coef_wr coincides with a tick -> first shadow committed, second stays pending (coef_busy = 1) and commits on the next cycle.
  - Push and pop in the same cycle at level 2 -> level stays 2.
- Reset mid-stream: rst asserted with level = 3 and a pending write -> level = 0, coef_busy = 0, coefficients back to passthrough; after release the first tick yields core_x = 0 and underrun_cnt = 1.

Source files
------------

// File: rtl/iir_input_scheduler.sv
// Paces buffered Q1.15 samples to iir_orde1_core, one per divider tick. Outputs are registered one cycle after the tick.
// s_ready is low at full with no same-cycle bypass. Coefficients are double-buffered and commit only on a tick.
module iir_input_scheduler #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic signed [DATA_W-1:0]        s_data,
    input  logic        [DIV_W-1:0]         div_ratio,
    input  logic                            coef_wr,
    input  logic signed [DATA_W-1:0]        coef_a0_in,
    input  logic signed [DATA_W-1:0]        coef_a1_in,
    input  logic signed [DATA_W-1:0]        coef_b1_in,
    input  logic                            coef_clr_req,
    output logic                            coef_busy,
    output logic                            core_en,
    output logic signed [DATA_W-1:0]        core_x,
    output logic                            core_clear,
    output logic signed [DATA_W-1:0]        core_a0,
    output logic signed [DATA_W-1:0]        core_a1,
    output logic signed [DATA_W-1:0]        core_b1,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [15:0]                     underrun_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic signed [DATA_W-1:0] UNITY = {1'b0, {(DATA_W-1){1'b1}}};

    logic signed [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]            level_q, level_d;
    logic [DIV_W-1:0]         cnt_q, cnt_d;

    logic signed [DATA_W-1:0] sh_a0_q, sh_a0_d;
    logic signed [DATA_W-1:0] sh_a1_q, sh_a1_d;
    logic signed [DATA_W-1:0] sh_b1_q, sh_b1_d;
    logic                     pend_q, pend_d;
    logic                     clr_q, clr_d;

    logic                     en_q, en_d;
    logic                     clear_q, clear_d;
    logic signed [DATA_W-1:0] x_q, x_d;
    logic signed [DATA_W-1:0] a0_q, a0_d;
    logic signed [DATA_W-1:0] a1_q, a1_d;
    logic signed [DATA_W-1:0] b1_q, b1_d;
    logic [15:0]              und_q, und_d;

    logic tick;
    logic push;
    logic pop;
    logic commit;
    logic commit_clr;
    logic emit;

    assign tick       = (cnt_q >= div_ratio);
    assign s_ready    = (level_q < LW'(FIFO_DEPTH));
    assign push       = s_valid && s_ready;
    assign commit     = tick && pend_q;
    // A clearing commit consumes the whole tick: no sample is released on it.
    assign commit_clr = commit && clr_q;
    assign emit       = tick && !commit_clr;
    assign pop        = emit && (level_q != '0);

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + DIV_W'(1);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    always_comb begin
        sh_a0_d = sh_a0_q;
        sh_a1_d = sh_a1_q;
        sh_b1_d = sh_b1_q;
        pend_d  = pend_q && !commit;
        clr_d   = clr_q && !commit;
        // A write on a tick lands after that tick's commit, so it stays pending.
        if (coef_wr) begin
            sh_a0_d = coef_a0_in;
            sh_a1_d = coef_a1_in;
            sh_b1_d = coef_b1_in;
            pend_d  = 1'b1;
            clr_d   = clr_d | coef_clr_req;
        end
    end

    always_comb begin
        en_d    = emit;
        clear_d = commit_clr;
        x_d     = x_q;
        a0_d    = a0_q;
        a1_d    = a1_q;
        b1_d    = b1_q;
        und_d   = und_q;
        if (commit) begin
            a0_d = sh_a0_q;
            a1_d = sh_a1_q;
            b1_d = sh_b1_q;
        end
        if (emit) begin
            if (level_q != '0) begin
                x_d = mem_q[rd_ptr_q];
            end else begin
                x_d = '0;
                if (und_q != 16'hFFFF) begin
                    und_d = und_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            sh_a0_q  <= '0;
            sh_a1_q  <= '0;
            sh_b1_q  <= '0;
            pend_q   <= 1'b0;
            clr_q    <= 1'b0;
            en_q     <= 1'b0;
            clear_q  <= 1'b0;
            x_q      <= '0;
            a0_q     <= UNITY;
            a1_q     <= '0;
            b1_q     <= '0;
            und_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            sh_a0_q  <= sh_a0_d;
            sh_a1_q  <= sh_a1_d;
            sh_b1_q  <= sh_b1_d;
            pend_q   <= pend_d;
            clr_q    <= clr_d;
            en_q     <= en_d;
            clear_q  <= clear_d;
            x_q      <= x_d;
            a0_q     <= a0_d;
            a1_q     <= a1_d;
            b1_q     <= b1_d;
            und_q    <= und_d;
        end
    end

    assign coef_busy    = pend_q;
    assign core_en      = en_q;
    assign core_clear   = clear_q;
    assign core_x       = x_q;
    assign core_a0      = a0_q;
    assign core_a1      = a1_q;
    assign core_b1      = b1_q;
    assign fifo_level   = level_q;
    assign underrun_cnt = und_q;

endmodule
